lockstep_fault_handler: RTL and testbench
=========================================

// Module: lockstep_fault_handler
// PURPOSE
//   Fault-reaction stage fed by the dual-core lockstep comparator's mismatch_now.
//   Filters transient mismatches, drives the cores to a safe state on a confirmed
//   fault and records the fault PC. Pulses a core reset after host acknowledge.
//   Locks permanently once MAX_RETRIES confirmed faults have occurred.
// PARAMETERS
//   CONFIRM_CYCLES  2  consecutive mismatch cycles to confirm a fault (>=1)
//   RST_PULSE       4  core_reset_req pulse length in cycles (>=1)
//   MAX_RETRIES     3  confirmed faults that cause LOCKED (>=1)
//   CNT_W           8  width of the fault/transient counters
// PORTS
//   clk              in   1      system clock, rising edge
//   reset_n          in   1      asynchronous, active-low reset
//   mismatch_now     in   1      combinational core0/core1 compare result
//   pc0              in   32     master-core PC, captured at the first mismatch cycle
//   fault_ack        in   1      host acknowledge; sampled only in FAULT
//   safe_state       out  1      stall/isolate both cores
//   fault_irq        out  1      fault interrupt to host (level)
//   core_reset_req   out  1      reset pulse request for both cores
//   fault_pc         out  32     pc0 from the first cycle of the last confirmed fault
//   fault_count      out  CNT_W  confirmed faults since reset, saturating
//   locked           out  1      permanent fault; cleared only by reset_n
//   state_dbg        out  3      current state encoding
// BEHAVIOUR
//   - All outputs are registered. Reset (async assert, sync deassert handled upstream)
//     clears all outputs to 0 and the state to IDLE, from any state, mid-pulse included.
//   - States: IDLE=0, CONFIRM=1, FAULT=2, RECOVER=3, LOCKED=4.
//   - IDLE: mismatch_now=1 -> capture pc0 into pend_pc and set cnt=1. The next state is
//     CONFIRM. If CONFIRM_CYCLES==1, the fault is confirmed immediately instead (see the
//     confirm rule).
//   - CONFIRM: mismatch_now=1 -> cnt+1. When cnt+1==CONFIRM_CYCLES, the fault is confirmed.
//     mismatch_now=0 -> IDLE (transient). Transients leave fault_count and fault_pc unchanged.
//   - Confirm rule: fault_pc<=pend_pc and fault_count<=fault_count+1 (saturate at all-ones).
//     If the new count >= MAX_RETRIES, go to LOCKED; otherwise go to FAULT.
//   - Latency: safe_state is high in cycle N+CONFIRM_CYCLES when mismatch_now is
//     high in cycles N..N+CONFIRM_CYCLES-1.
//   - FAULT: safe_state=1, fault_irq=1. fault_ack=1 -> RECOVER. mismatch_now is ignored.
//   - RECOVER: safe_state=1, fault_irq=0, core_reset_req=1 for exactly RST_PULSE cycles.
//     Then go to IDLE with safe_state=0. mismatch_now is ignored for the whole pulse.
//   - LOCKED: safe_state=1, fault_irq=1, locked=1. This state is absorbing; fault_ack is ignored.
//   - fault_ack is ignored outside FAULT. The ack never shortens or extends the pulse.
// CONFIGURATION
//   LOCKSTEP_TRANSIENT_LOG_EN defined:
//     - Adds output transient_count[CNT_W-1:0], reset 0.
//     - It increments, saturating, on every CONFIRM->IDLE transition.
//   LOCKSTEP_TRANSIENT_LOG_EN undefined: the port and the counter are absent.
//     Behaviour is otherwise identical.
// TESTING
//   T1: mismatch high 1 cycle, defaults -> IDLE->CONFIRM->IDLE, safe_state stays 0,
//       fault_count=0 (transient_count=1 with macro).
//   T2: mismatch high 2 cycles with pc0=0x40 at the first one -> safe_state/fault_irq=1
//       2 cycles after the first mismatch, fault_pc=0x40, fault_count=1.
//   T3: from T2, fault_ack=1 for one cycle -> core_reset_req high exactly 4 cycles,
//       then IDLE, safe_state=0, fault_irq=0.
//   T4: three confirmed faults, each acked -> the third goes to LOCKED, locked=1,
//       fault_count=3, fault_ack ignored.
//   T5: reset_n low during RECOVER cycle 2 -> all outputs 0 immediately, IDLE afterwards.
//   T6: mismatch held high throughout RECOVER -> no new fault. A new fault is confirmed
//       only after IDLE plus CONFIRM_CYCLES cycles.

Source files
------------

// File: rtl/lockstep_fault_handler.sv
// Lockstep fault-reaction stage.
// Filters transient core0/core1 mismatches, parks both cores in a safe state on a
// confirmed fault, records the fault PC, pulses a core reset after the host acks,
// and locks permanently after MAX_RETRIES confirmed faults.
// Optional feature: define LOCKSTEP_TRANSIENT_LOG_EN to add a saturating
// transient_count output that counts filtered (CONFIRM->IDLE) mismatches.
module lockstep_fault_handler #(
    parameter int unsigned CONFIRM_CYCLES = 2,
    parameter int unsigned RST_PULSE      = 4,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mismatch_now,
    input  logic [31:0]      pc0,
    input  logic             fault_ack,
    output logic             safe_state,
    output logic             fault_irq,
    output logic             core_reset_req,
    output logic [31:0]      fault_pc,
    output logic [CNT_W-1:0] fault_count,
    output logic             locked,
    output logic [2:0]       state_dbg
`ifdef LOCKSTEP_TRANSIENT_LOG_EN
    ,
    output logic [CNT_W-1:0] transient_count
`endif
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StConfirm = 3'd1,
        StFault   = 3'd2,
        StRecover = 3'd3,
        StLocked  = 3'd4
    } state_e;

    localparam int unsigned ConfW  = $clog2(CONFIRM_CYCLES + 1);
    localparam int unsigned PulseW = $clog2(RST_PULSE + 1);

    localparam logic [ConfW-1:0]  ConfLast  = ConfW'(CONFIRM_CYCLES - 1);
    localparam logic [PulseW-1:0] PulseLast = PulseW'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]  CntMax    = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [ConfW-1:0]   conf_cnt_q, conf_cnt_d;
    logic [PulseW-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [31:0]        fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]   fault_count_q, fault_count_d;
    logic [CNT_W-1:0]   fault_count_inc;
    logic               confirm;
    logic [31:0]        confirm_pc;
    logic               transient;
    logic               safe_q, safe_d;
    logic               irq_q, irq_d;
    logic               rst_req_q, rst_req_d;
    logic               locked_q, locked_d;

    // Saturating increment of the confirmed-fault counter.
    always_comb begin
        fault_count_inc = fault_count_q;
        if (fault_count_q != CntMax) begin
            fault_count_inc = fault_count_q + 1'b1;
        end
    end

    // Next-state logic: mismatch filtering, fault confirmation and recovery timing.
    always_comb begin
        state_d       = state_q;
        conf_cnt_d    = conf_cnt_q;
        pulse_cnt_d   = pulse_cnt_q;
        pend_pc_d     = pend_pc_q;
        fault_pc_d    = fault_pc_q;
        fault_count_d = fault_count_q;
        confirm       = 1'b0;
        confirm_pc    = pend_pc_q;
        transient     = 1'b0;

        case (state_q)
            StIdle: begin
                if (mismatch_now) begin
                    pend_pc_d  = pc0;
                    conf_cnt_d = ConfW'(1);
                    if (CONFIRM_CYCLES == 1) begin
                        // Single-cycle filter: the first mismatch already confirms.
                        confirm    = 1'b1;
                        confirm_pc = pc0;
                    end else begin
                        state_d = StConfirm;
                    end
                end
            end
            StConfirm: begin
                if (mismatch_now) begin
                    if (conf_cnt_q == ConfLast) begin
                        confirm = 1'b1;
                    end else begin
                        conf_cnt_d = conf_cnt_q + 1'b1;
                    end
                end else begin
                    state_d   = StIdle;
                    transient = 1'b1;
                end
            end
            StFault: begin
                if (fault_ack) begin
                    state_d     = StRecover;
                    pulse_cnt_d = '0;
                end
            end
            StRecover: begin
                // Pulse length is fixed; mismatch and ack are both ignored here.
                if (pulse_cnt_q == PulseLast) begin
                    state_d = StIdle;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            StLocked: begin
                state_d = StLocked;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (confirm) begin
            fault_pc_d    = confirm_pc;
            fault_count_d = fault_count_inc;
            if (32'(fault_count_inc) >= MAX_RETRIES) begin
                state_d = StLocked;
            end else begin
                state_d = StFault;
            end
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        safe_d    = (state_d == StFault) || (state_d == StRecover) || (state_d == StLocked);
        irq_d     = (state_d == StFault) || (state_d == StLocked);
        rst_req_d = (state_d == StRecover);
        locked_d  = (state_d == StLocked);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            conf_cnt_q    <= '0;
            pulse_cnt_q   <= '0;
            pend_pc_q     <= '0;
            fault_pc_q    <= '0;
            fault_count_q <= '0;
            safe_q        <= 1'b0;
            irq_q         <= 1'b0;
            rst_req_q     <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            conf_cnt_q    <= conf_cnt_d;
            pulse_cnt_q   <= pulse_cnt_d;
            pend_pc_q     <= pend_pc_d;
            fault_pc_q    <= fault_pc_d;
            fault_count_q <= fault_count_d;
            safe_q        <= safe_d;
            irq_q         <= irq_d;
            rst_req_q     <= rst_req_d;
            locked_q      <= locked_d;
        end
    end

`ifdef LOCKSTEP_TRANSIENT_LOG_EN
    logic [CNT_W-1:0] transient_q;

    // Saturating count of filtered transient mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            transient_q <= '0;
        end else if (transient && (transient_q != CntMax)) begin
            transient_q <= transient_q + 1'b1;
        end
    end

    assign transient_count = transient_q;
`else
    logic unused_transient;
    assign unused_transient = transient;
`endif

    assign safe_state     = safe_q;
    assign fault_irq      = irq_q;
    assign core_reset_req = rst_req_q;
    assign fault_pc       = fault_pc_q;
    assign fault_count    = fault_count_q;
    assign locked         = locked_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_lockstep_fault_handler.sv
// Scoreboard bench for lockstep_fault_handler (default parameters).
// Stimulus drives inputs on the falling edge and pushes the expected post-edge
// outputs from a behavioural model; a monitor pops and compares after each
// rising edge.
module tb_lockstep_fault_handler;

    localparam int unsigned ConfirmCycles = 2;
    localparam int unsigned RstPulse      = 4;
    localparam int unsigned MaxRetries    = 3;
    localparam int unsigned CntW          = 8;

    logic            clk;
    logic            reset_n;
    logic            mismatch_now;
    logic [31:0]     pc0;
    logic            fault_ack;
    logic            safe_state;
    logic            fault_irq;
    logic            core_reset_req;
    logic [31:0]     fault_pc;
    logic [CntW-1:0] fault_count;
    logic            locked;
    logic [2:0]      state_dbg;
    logic [CntW-1:0] transient_count;

    lockstep_fault_handler #(
        .CONFIRM_CYCLES(ConfirmCycles),
        .RST_PULSE     (RstPulse),
        .MAX_RETRIES   (MaxRetries),
        .CNT_W         (CntW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mismatch_now  (mismatch_now),
        .pc0           (pc0),
        .fault_ack     (fault_ack),
        .safe_state    (safe_state),
        .fault_irq     (fault_irq),
        .core_reset_req(core_reset_req),
        .fault_pc      (fault_pc),
        .fault_count   (fault_count),
        .locked        (locked),
        .state_dbg     (state_dbg)
`ifdef LOCKSTEP_TRANSIENT_LOG_EN
        ,
        .transient_count(transient_count)
`endif
    );

`ifndef LOCKSTEP_TRANSIENT_LOG_EN
    assign transient_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        safe;
        logic        irq;
        logic        rreq;
        logic        lk;
        logic [31:0] fpc;
        logic [31:0] fcnt;
        logic [31:0] tcnt;
        logic [31:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    bit   started = 0;

    // Behavioural model: mode name plus mismatch streak and remaining pulse cycles.
    typedef enum int {MIdle = 0, MConfirm = 1, MFault = 2, MRecover = 3, MLocked = 4} mode_e;
    mode_e       m_mode;
    int          m_streak;
    int          m_left;
    logic [31:0] m_pend;
    logic [31:0] m_fpc;
    int          m_fcnt;
    int          m_tcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode   = MIdle;
        m_streak = 0;
        m_left   = 0;
        m_pend   = '0;
        m_fpc    = '0;
        m_fcnt   = 0;
        m_tcnt   = 0;
    endfunction

    function automatic void model_confirm();
        m_fpc = m_pend;
        if (m_fcnt < (1 << CntW) - 1) m_fcnt++;
        m_mode   = (m_fcnt >= MaxRetries) ? MLocked : MFault;
        m_streak = 0;
    endfunction

    function automatic void model_step(input logic mm, input logic [31:0] pc, input logic ack);
        case (m_mode)
            MIdle, MConfirm: begin
                if (mm) begin
                    if (m_streak == 0) m_pend = pc;
                    m_streak++;
                    if (m_streak >= ConfirmCycles) model_confirm();
                    else m_mode = MConfirm;
                end else begin
                    if (m_mode == MConfirm && m_tcnt < (1 << CntW) - 1) m_tcnt++;
                    m_mode   = MIdle;
                    m_streak = 0;
                end
            end
            MFault: begin
                if (ack) begin
                    m_mode = MRecover;
                    m_left = RstPulse;
                end
            end
            MRecover: begin
                m_left--;
                if (m_left == 0) m_mode = MIdle;
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.safe = (m_mode == MFault) || (m_mode == MRecover) || (m_mode == MLocked);
        e.irq  = (m_mode == MFault) || (m_mode == MLocked);
        e.rreq = (m_mode == MRecover);
        e.lk   = (m_mode == MLocked);
        e.fpc  = m_fpc;
        e.fcnt = 32'(m_fcnt);
        e.tcnt = 32'(m_tcnt);
        e.st   = 32'(int'(m_mode));
        return e;
    endfunction

    task automatic compare_all(input exp_t e, input string tag);
        check({tag, ".safe_state"},     32'(safe_state),     32'(e.safe));
        check({tag, ".fault_irq"},      32'(fault_irq),      32'(e.irq));
        check({tag, ".core_reset_req"}, 32'(core_reset_req), 32'(e.rreq));
        check({tag, ".locked"},         32'(locked),         32'(e.lk));
        check({tag, ".fault_pc"},       fault_pc,            e.fpc);
        check({tag, ".fault_count"},    32'(fault_count),    e.fcnt);
        check({tag, ".state_dbg"},      32'(state_dbg),      e.st);
`ifdef LOCKSTEP_TRANSIENT_LOG_EN
        check({tag, ".transient_count"}, 32'(transient_count), e.tcnt);
`endif
    endtask

    // One clock of stimulus: drive on the falling edge, push what the next rising
    // edge must produce.
    task automatic step(input logic rst_n, input logic mm, input logic [31:0] pc,
                        input logic ack);
        exp_t e;
        @(negedge clk);
        reset_n      = rst_n;
        mismatch_now = mm;
        pc0          = pc;
        fault_ack    = ack;
        if (!rst_n) model_reset();
        else        model_step(mm, pc, ack);
        e = model_out();
        exp_q.push_back(e);
        started = 1;
        if (!rst_n) begin
            // Reset is asynchronous: outputs must already be clear.
            #1;
            compare_all(e, "async_reset");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom(), 1'b0);
    endtask

    task automatic raise_fault(input logic [31:0] pc);
        step(1'b1, 1'b1, pc, 1'b0);
        for (int i = 1; i < ConfirmCycles; i++) step(1'b1, 1'b1, $urandom(), 1'b0);
    endtask

    // Monitor: compares one expectation after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
                end else begin
                    compare_all(exp_q.pop_front(), "cycle");
                end
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        mismatch_now = 1'b0;
        pc0          = '0;
        fault_ack    = 1'b0;
        model_reset();

        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // T1: single-cycle transient.
        step(1'b1, 1'b1, 32'h1234, 1'b0);
        idle(3);

        // T2: confirmed fault at pc 0x40.
        raise_fault(32'h40);
        idle(3);

        // T3: ack gives a fixed-length reset pulse.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        idle(RstPulse + 2);

        // T4: two more faults reach the lock; acks afterwards are ignored.
        for (int f = 0; f < 2; f++) begin
            raise_fault(32'h100 + 32'(f));
            idle(2);
            step(1'b1, 1'b0, 32'h0, 1'b1);
            idle(RstPulse + 1);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom(), 1'b1);

        // T5: reset during the second RECOVER cycle.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        raise_fault(32'h200);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        idle(3);

        // T6: mismatch held through RECOVER and beyond.
        raise_fault(32'h300);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < RstPulse + ConfirmCycles + 3; i++)
            step(1'b1, 1'b1, 32'h400 + 32'(i), 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        idle(RstPulse + 1);

        // Randomized episodes, each starting from reset.
        for (int ep = 0; ep < 40; ep++) begin
            int mm_pct;
            int ack_pct;
            mm_pct  = int'($urandom_range(10, 80));
            ack_pct = int'($urandom_range(5, 40));
            step(1'b0, 1'b0, 32'h0, 1'b0);
            for (int c = 0; c < 60; c++) begin
                step(1'b1, ($urandom_range(0, 99) < mm_pct), $urandom(),
                     ($urandom_range(0, 99) < ack_pct));
            end
        end

        idle(2);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
